// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: NOP/HALT encodings and the fetch-stage FSM state type.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } if_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Word-organised instruction memory: one synchronous write port for the debug loader,
// one combinational read port for fetch. Contents are never reset.
module instruction_memory #(
  parameter  int NB_DATA    = 32,
  parameter  int IMEM_DEPTH = 256,
  localparam int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [NB_DATA-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [NB_DATA-1:0] rdata
);

  logic [NB_DATA-1:0] mem [IMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// MIPS instruction-fetch stage: PC register, instruction memory and IF/ID register.
// Define IF_HALT_DETECT_EN to enable HALT-word detection, the HALTED state and o_halt.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int NB_DATA    = 32,
  parameter int IMEM_DEPTH = 256
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [NB_DATA-1:0] i_redirect_pc,
  input  logic               i_mem_we,
  input  logic [NB_DATA-1:0] i_mem_waddr,
  input  logic [NB_DATA-1:0] i_mem_wdata,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_DATA-1:0] o_pcounter4,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_halt
);

  localparam int AW = $clog2(IMEM_DEPTH);

  if_state_t          state;
  logic [NB_DATA-1:0] pc_p0;
  logic [NB_DATA-1:0] pc_next_p0;
  logic [NB_DATA-1:0] fetch_p0;
  logic [NB_DATA-1:0] instr_p1;
  logic [NB_DATA-1:0] pc4_p1;
  logic               mem_we;

  // Word index ignores the byte offset and any PC bits above the memory depth.
  assign mem_we     = i_mem_we && (state != ST_RUN);
  assign pc_next_p0 = pc_p0 + NB_DATA'(4);

  instruction_memory #(
    .NB_DATA   (NB_DATA),
    .IMEM_DEPTH(IMEM_DEPTH)
  ) u_imem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(i_mem_waddr[AW+1:2]),
    .wdata(i_mem_wdata),
    .raddr(pc_p0[AW+1:2]),
    .rdata(fetch_p0)
  );

`ifdef IF_HALT_DETECT_EN
  logic halt_p1;
  assign o_halt = halt_p1;
`else
  assign o_halt = 1'b0;
`endif

  // Stage 0 -> 1: PC update and IF/ID latch
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      pc_p0    <= '0;
      instr_p1 <= NOP_INSTR;
      pc4_p1   <= '0;
`ifdef IF_HALT_DETECT_EN
      halt_p1  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_HALTED: begin
          // The HALT word is allowed one cycle in IF/ID, then a bubble follows.
          if (state == ST_HALTED) begin
            instr_p1 <= NOP_INSTR;
            pc4_p1   <= '0;
          end
          if (i_start) begin
            state    <= ST_RUN;
            pc_p0    <= '0;
            instr_p1 <= NOP_INSTR;
            pc4_p1   <= '0;
`ifdef IF_HALT_DETECT_EN
            halt_p1  <= 1'b0;
`endif
          end
        end
        ST_RUN: begin
          if (i_enable) begin
            if (i_redirect) begin
              pc_p0    <= {i_redirect_pc[NB_DATA-1:2], 2'b00};
              instr_p1 <= NOP_INSTR;
              pc4_p1   <= '0;
            end else if (!i_stall) begin
              instr_p1 <= fetch_p0;
              pc4_p1   <= pc_next_p0;
`ifdef IF_HALT_DETECT_EN
              if (fetch_p0 == HALT_WORD) begin
                state   <= ST_HALTED;
                halt_p1 <= 1'b1;
              end else begin
                pc_p0   <= pc_next_p0;
              end
`else
              pc_p0    <= pc_next_p0;
`endif
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_instruction = instr_p1;
  assign o_pcounter4   = pc4_p1;
  assign o_pc          = pc_p0;

  // Byte-offset and out-of-range address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_mem_waddr[NB_DATA-1:AW+2], i_mem_waddr[1:0],
                              i_redirect_pc[1:0]};

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: table-driven run sequence plus
// hand-written reset, HALT and restart sequences.
module tb_instruction_fetch;

  localparam int NB_DATA = 32;
  localparam logic [31:0] W0   = 32'h2001_0005;
  localparam logic [31:0] W1   = 32'h2002_0007;
  localparam logic [31:0] W2   = 32'h2003_000A;
  localparam logic [31:0] W4   = 32'h2005_000C;
  localparam logic [31:0] W16  = 32'h8C04_0010;
  localparam logic [31:0] W17  = 32'h0000_0020;
  localparam logic [31:0] W255 = 32'h1234_5678;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] WNEW = 32'hAAAA_5555;

  logic               clk = 1'b0;
  logic               i_rst_n = 1'b1;
  logic               i_start = 1'b0;
  logic               i_enable = 1'b0;
  logic               i_stall = 1'b0;
  logic               i_redirect = 1'b0;
  logic [NB_DATA-1:0] i_redirect_pc = '0;
  logic               i_mem_we = 1'b0;
  logic [NB_DATA-1:0] i_mem_waddr = '0;
  logic [NB_DATA-1:0] i_mem_wdata = '0;
  logic [NB_DATA-1:0] o_instruction;
  logic [NB_DATA-1:0] o_pcounter4;
  logic [NB_DATA-1:0] o_pc;
  logic               o_halt;

  int checks = 0;
  int failures = 0;

  instruction_fetch #(.NB_DATA(NB_DATA), .IMEM_DEPTH(256)) dut (
    .clk          (clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_enable     (i_enable),
    .i_stall      (i_stall),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .i_mem_we     (i_mem_we),
    .i_mem_waddr  (i_mem_waddr),
    .i_mem_wdata  (i_mem_wdata),
    .o_instruction(o_instruction),
    .o_pcounter4  (o_pcounter4),
    .o_pc         (o_pc),
    .o_halt       (o_halt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        start;
    logic        en;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    logic [31:0] e_pc;
    logic        e_halt;
  } vec_t;

  vec_t vecs [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int idx, input logic [31:0] ei,
                         input logic [31:0] ep4, input logic [31:0] epc, input logic eh);
    chk({nm, ".instr"}, idx, o_instruction, ei);
    chk({nm, ".pc4"},   idx, o_pcounter4,   ep4);
    chk({nm, ".pc"},    idx, o_pc,          epc);
    chk({nm, ".halt"},  idx, 32'(o_halt),   32'(eh));
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    i_mem_we    = 1'b1;
    i_mem_waddr = addr;
    i_mem_wdata = data;
    step();
    i_mem_we    = 1'b0;
  endtask

  initial begin
    //            start en stall redir rpc           we waddr   wdata         instr  pc4           pc            halt
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 32'h0,        32'h0, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 32'h0,        W0,    32'h4,        32'h4,        1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 32'h0,        W1,    32'h8,        32'h8,        1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0, 32'h0,        W1,    32'h8,        32'h8,        1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0, 32'h0,        W1,    32'h8,        32'h8,        1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 32'h0,        W2,    32'hC,        32'hC,        1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h80,       1'b0, 32'h0, 32'h0,        W2,    32'hC,        32'hC,        1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h43,       1'b0, 32'h0, 32'h0,        32'h0, 32'h0,        32'h40,       1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 32'h0,        W16,   32'h44,       32'h44,       1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 32'h0,        W17,   32'h48,       32'h48,       1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h400,      1'b0, 32'h0, 32'h0,        32'h0, 32'h0,        32'h400,      1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 32'h0,        W0,    32'h404,      32'h404,      1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 32'h0,        32'h0, 32'h0,        32'hFFFFFFFC, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 32'h0,        W255,  32'h0,        32'h0,        1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4, 32'hDEADBEEF, W0,    32'h4,        32'h4,        1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0, 32'h0,        W1,    32'h8,        32'h8,        1'b0};

    // Power-on reset
    #3 i_rst_n = 1'b0;
    step();
    step();
    chk_all("reset", 0, 32'h0, 32'h0, 32'h0, 1'b0);
    i_rst_n = 1'b1;

    load(32'h0,   W0);
    load(32'h4,   W1);
    load(32'h8,   W2);
    load(32'hC,   32'h2004_000B);
    load(32'h10,  W4);
    load(32'h40,  W16);
    load(32'h44,  W17);
    load(32'h3FC, W255);
    chk_all("idle_after_load", 0, 32'h0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      i_start       = vecs[i].start;
      i_enable      = vecs[i].en;
      i_stall       = vecs[i].stall;
      i_redirect    = vecs[i].redir;
      i_redirect_pc = vecs[i].rpc;
      i_mem_we      = vecs[i].we;
      i_mem_waddr   = vecs[i].waddr;
      i_mem_wdata   = vecs[i].wdata;
      step();
      chk_all("vec", i, vecs[i].e_instr, vecs[i].e_pc4, vecs[i].e_pc, vecs[i].e_halt);
    end
    i_start = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_mem_we = 1'b0;

    // Mid-run reset clears outputs without waiting for an edge
    i_rst_n = 1'b0;
    #2;
    chk_all("async_reset", 0, 32'h0, 32'h0, 32'h0, 1'b0);
    #1 i_rst_n = 1'b1;

    // IDLE does not fetch even with enable high; loader writes HALT at word 3
    i_enable = 1'b1;
    load(32'hC, HALT);
    chk_all("idle_hold", 0, 32'h0, 32'h0, 32'h0, 1'b0);

    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk_all("restart", 0, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    chk_all("mem_retained", 0, W0, 32'h4, 32'h4, 1'b0);
    step();
    chk_all("mem_retained", 1, W1, 32'h8, 32'h8, 1'b0);
    step();
    chk_all("mem_retained", 2, W2, 32'hC, 32'hC, 1'b0);
    step();
`ifdef IF_HALT_DETECT_EN
    chk_all("halt_fetch", 0, HALT, 32'h10, 32'hC, 1'b1);
    step();
    chk_all("halt_bubble", 0, 32'h0, 32'h0, 32'hC, 1'b1);
    load(32'h4, WNEW);
    chk_all("halt_frozen", 0, 32'h0, 32'h0, 32'hC, 1'b1);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk_all("halt_restart", 0, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    chk_all("halt_restart", 1, W0, 32'h4, 32'h4, 1'b0);
    step();
    chk_all("halted_write", 0, WNEW, 32'h8, 32'h8, 1'b0);
`else
    chk_all("no_halt", 0, HALT, 32'h10, 32'h10, 1'b0);
    step();
    chk_all("no_halt", 1, W4, 32'h14, 32'h14, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. Holds the program counter and a word-organised instruction memory loaded by the debug unit, and drives the IF/ID pipeline register (`o_instruction`, `o_pcounter4`) consumed by decode. Supports hazard stalls, branch/jump redirect with flush, single-step enable and HALT detection.

## Interface
- `NB_DATA`, 32, instruction/PC width
- `IMEM_DEPTH`, 256, instruction memory depth in 32-bit words (power of two)
- `clk`  in  1  pipeline clock
- `i_rst_n`  in  1  reset; one clock, asynchronous, active-low
- `i_start`  in  1  start/restart pulse from debug unit
- `i_enable`  in  1  step enable; stage advances only when high
- `i_stall`  in  1  hazard-unit stall
- `i_redirect`  in  1  branch/jump taken
- `i_redirect_pc`  in  NB_DATA  redirect target byte address
- `i_mem_we`  in  1  loader write strobe
- `i_mem_waddr`  in  NB_DATA  loader byte address
- `i_mem_wdata`  in  NB_DATA  loader write word
- `o_instruction`  out  NB_DATA  IF/ID instruction
- `o_pcounter4`  out  NB_DATA  IF/ID PC+4
- `o_pc`  out  NB_DATA  current PC register
- `o_halt`  out  1  HALT fetched, stage frozen

## Operation
- FSM states: IDLE, RUN, HALTED. Reset -> IDLE.
- IDLE/HALTED: `i_start` -> RUN with PC <= 0 and IF/ID <= NOP (0x00000000, PC+4 = 0); `o_halt` cleared.
- RUN -> HALTED: fetched word equals HALT_WORD (0xFFFFFFFF) on an advancing cycle (macro-dependent).
- Memory index = PC[log2(IMEM_DEPTH)+1:2]; higher PC bits ignored, so fetch address wraps modulo IMEM_DEPTH words.
- Loader writes: word index from `i_mem_waddr` the same way; accepted in IDLE and HALTED, ignored in RUN.
- Per-cycle action in RUN with `i_enable`=1, priority order:
  - `i_redirect`: PC <= {i_redirect_pc[31:2], 2'b00}; IF/ID <= NOP. Overrides `i_stall`.
  - `i_stall`: PC and IF/ID hold.
  - otherwise: IF/ID <= {mem[PC], PC+4}; PC <= PC+4 (32-bit wrap, 0xFFFFFFFC -> 0).
- RUN with `i_enable`=0: everything holds, including under `i_redirect` (the debug unit holds the whole pipeline).
- HALT fetch: HALT_WORD is latched into IF/ID so it flows downstream; PC holds at the HALT address; next cycle IF/ID <= NOP.
- Reset values: PC 0, `o_instruction` 0, `o_pcounter4` 0, `o_halt` 0, state IDLE. Memory contents are not reset.

## Timing
- Memory: synchronous write, combinational read; fetch latency is one edge (PC to IF/ID).
- Redirect asserted before edge n: target word appears on `o_instruction` after edge n+1; the IF/ID output after edge n is NOP.
- Start pulse at edge n: word 0 appears on `o_instruction` after edge n+1.
- `o_halt` rises at the same edge that latches HALT_WORD into IF/ID.
- Reset asserted mid-operation clears all registers immediately; deassertion takes effect at the next edge.

## Configuration
- `IF_HALT_DETECT_EN` defined: HALT detection, HALTED state and `o_halt` are active as described.
- Not defined: 0xFFFFFFFF is an ordinary instruction; the FSM never enters HALTED; `o_halt` is tied to 0.

## Structure
- Shared package `mips_pkg`: NOP_INSTR, HALT_WORD and FSM state encoding.
- Sub-module `instruction_memory`: IMEM_DEPTH×32, one synchronous write port, one asynchronous read port.

## Test plan
- Load 0x20010005 at byte address 0 and 0x20020007 at byte address 4, pulse `i_start`, hold `i_enable`=1 -> `o_instruction`/`o_pcounter4` are 0x20010005/4 after edge 1 and 0x20020007/8 after edge 2.
- `i_stall`=1 for 2 cycles while PC=8 -> `o_pc` stays 8, IF/ID outputs unchanged; advance resumes at 12.
- `i_redirect`=1 with `i_stall`=1 and `i_redirect_pc`=0x43 -> PC=0x40, next IF/ID is NOP, then mem[16]/0x44.
- HALT_WORD at word 3 -> `o_halt`=1 with `o_instruction`=0xFFFFFFFF, PC frozen at 12, later IF/ID=NOP; a loader write now succeeds; `i_start` restarts at PC 0. Repeat without the macro -> no halt, PC reaches 16.
- Loader write during RUN -> memory unchanged; `i_enable`=0 -> all outputs hold.
- Assert `i_rst_n`=0 mid-run -> all outputs 0 immediately, state IDLE, memory retained.
